dmem_req_ctrl: RTL and testbench
================================

# dmem_req_ctrl

Parametrised data-memory request controller between the pipeline's memory stage and the L1 dcache. It drives dcache requests, holds the pipeline enable low until the request completes, and latches load data across downstream stalls. It also tracks an LL/SC reservation, invalidated by coherence snoops, and counts memory stall cycles for performance monitoring. It replaces the ad-hoc dhit/enable hold logic in the datapath top.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STALL_CNT_W, 16, width of the stall counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_ren  in  1  memory stage load (LL when req_atomic=1).
- req_wen  in  1  memory stage store (SC when req_atomic=1).
- req_atomic  in  1  LL/SC qualifier.
- req_addr  in  ADDR_W  effective address.
- req_wdata  in  DATA_W  store data.
- halt  in  1  halt reached in the memory or writeback stage; suppresses all requests.
- pipe_ready  in  1  all other stages are able to advance.
- dhit  in  1  dcache completion.
- dmemload  in  DATA_W  dcache read data.
- snoop_valid  in  1  coherence invalidation valid.
- snoop_addr  in  ADDR_W  invalidated address.
- stall_clr  in  1  synchronous clear of stall_count.
- dmemREN, dmemWEN, datomic  out  1  dcache request strobes.
- dmemaddr  out  ADDR_W  dcache address.
- dmemstore  out  DATA_W  dcache store data.
- enable  out  1  pipeline advance; latches update at the edge where enable=1.
- load_data  out  DATA_W  value presented to writeback.
- stall_count  out  STALL_CNT_W  saturating memory-stall cycle count.

## Operation
- mem_req = (req_ren | req_wen) & ~halt & ~sc_fail.
- sc_fail = req_wen & req_atomic & ~(resv_valid & resv_addr[ADDR_W-1:2]==req_addr[ADDR_W-1:2]).
- Two states: IDLE and HELD.

IDLE:
- dmemREN = req_ren & mem_req; dmemWEN = req_wen & mem_req; datomic = req_atomic & mem_req.
- dmemaddr = req_addr; dmemstore = req_wdata.
- mem_done = ~mem_req | dhit.
- enable = mem_done & pipe_ready.
- load_data selection:
  - dmemload when a load hits.
  - 1 when an SC hits.
  - 0 when sc_fail.
  - otherwise the held register.
- Transition: if mem_req & dhit & ~pipe_ready, capture load_data into load_reg and go to HELD.

HELD:
- All request strobes are 0.
- load_data = load_reg.
- enable = pipe_ready.
- On pipe_ready, return to IDLE.
- The dcache is never re-requested for a completed access.

Reservation (resv_valid, resv_addr):
- Set on an LL hit.
- Cleared by:
  - any SC, on hit or fail;
  - an own non-atomic store hit with a matching word address;
  - snoop_valid with a matching word address (bits [ADDR_W-1:2]).
- If a snoop matches in the same cycle as an LL hit to the same word, the snoop wins and the reservation stays clear.

Stall counter:
- Increments each cycle with IDLE & mem_req & ~dhit.
- Saturates at all-ones.
- stall_clr has priority over increment.

## Timing
- Hit latency: dhit to enable is combinational, 0 cycles. A hit with pipe_ready set advances the pipeline in the same cycle.
- A failed SC completes in the issuing cycle with no dcache request.
- After a hit with pipe_ready low, requests drop on the next cycle. load_data stays stable until the advancing edge.
- halt asserted while waiting: strobes drop immediately and enable follows pipe_ready.
- Reset values:
  - state=IDLE; resv_valid=0; resv_addr=0; load_reg=0; stall_count=0.
  - Outputs combinationally follow from these values.
- Reset asserted mid-request: the request is abandoned and the reservation is lost.

## Configuration
- DMEM_LLSC_EN defined: the reservation logic above is present. SC can fail locally. SC results are generated as 1/0.
- DMEM_LLSC_EN undefined:
  - No reservation registers exist and sc_fail=0.
  - datomic = req_atomic & mem_req, and the dcache owns LL/SC semantics.
  - An SC completes only on dhit, with load_data = dmemload.
  - snoop_valid and snoop_addr are ignored.

## Test plan
- Load at 0x100 with dhit 3 cycles later and pipe_ready=1: enable=0 for 3 cycles, then load_data=dmemload=0xDEADBEEF with enable=1 on the hit cycle; stall_count=3.
- Store hit with pipe_ready=0 for 2 cycles: dmemWEN drops after the hit cycle; enable rises when pipe_ready=1; exactly one dcache request is issued.
- LL 0x200 hit, then SC 0x200 hit: load_data=1 on the SC and the reservation is cleared. A second SC to 0x200 fails in 1 cycle with dmemWEN=0 and load_data=0.
- LL 0x200, snoop 0x203, then SC 0x200: the SC fails. LL hit and snoop 0x200 in the same cycle: the reservation stays clear.
- halt=1 with req_ren=1: all strobes are 0 and enable=pipe_ready. stall_count with 2^STALL_CNT_W+5 stall cycles reads all-ones.
- RST asserted during an outstanding load: outputs return to reset values at once; the next cycle is IDLE with resv_valid=0.

Source files
------------

// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: drives dcache strobes, holds enable until completion, latches load data.
// Optional LL/SC reservation tracking is enabled by defining DMEM_LLSC_EN.
module dmem_req_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   req_ren,
    input  logic                   req_wen,
    input  logic                   req_atomic,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic                   halt,
    input  logic                   pipe_ready,
    input  logic                   dhit,
    input  logic [DATA_W-1:0]      dmemload,
    input  logic                   snoop_valid,
    input  logic [ADDR_W-1:0]      snoop_addr,
    input  logic                   stall_clr,
    output logic                   dmemREN,
    output logic                   dmemWEN,
    output logic                   datomic,
    output logic [ADDR_W-1:0]      dmemaddr,
    output logic [DATA_W-1:0]      dmemstore,
    output logic                   enable,
    output logic [DATA_W-1:0]      load_data,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic {IDLE, HELD} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] load_reg;
    logic              mem_req;
    logic              sc_fail;
    logic              sc_req;
    logic              stall_inc;

    assign sc_req = req_wen & req_atomic;

`ifdef DMEM_LLSC_EN
    logic              resv_valid;
    logic [ADDR_W-1:0] resv_addr;
    logic              resv_match;
    logic              ll_hit;
    logic              sc_done;
    logic              st_clr;
    logic              snoop_hit;
    logic              snoop_on_ll;

    assign resv_match  = resv_valid && (resv_addr[ADDR_W-1:2] == req_addr[ADDR_W-1:2]);
    assign sc_fail     = sc_req & ~resv_match;
    assign ll_hit      = (state == IDLE) & mem_req & dhit & req_ren & req_atomic;
    assign sc_done     = (state == IDLE) & sc_req & ~halt & (sc_fail | (mem_req & dhit));
    assign st_clr      = (state == IDLE) & mem_req & dhit & req_wen & ~req_atomic & resv_match;
    assign snoop_hit   = snoop_valid && (snoop_addr[ADDR_W-1:2] == resv_addr[ADDR_W-1:2]);
    assign snoop_on_ll = snoop_valid && (snoop_addr[ADDR_W-1:2] == req_addr[ADDR_W-1:2]);

    // A snoop to the same word as a concurrent LL hit leaves the reservation clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else if (ll_hit) begin
            resv_valid <= ~snoop_on_ll;
            resv_addr  <= req_addr;
        end else if (sc_done | st_clr | snoop_hit) begin
            resv_valid <= 1'b0;
        end
    end
`else
    logic unused_snoop;

    assign sc_fail      = 1'b0;
    assign unused_snoop = snoop_valid ^ (^snoop_addr);
`endif

    assign mem_req   = (req_ren | req_wen) & ~halt & ~sc_fail;
    assign stall_inc = (state == IDLE) & mem_req & ~dhit;

    always_comb begin
        state_nxt = state;
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        datomic   = 1'b0;
        dmemaddr  = req_addr;
        dmemstore = req_wdata;
        enable    = pipe_ready;
        load_data = load_reg;
        case (state)
            IDLE: begin
                dmemREN = req_ren & mem_req;
                dmemWEN = req_wen & mem_req;
                datomic = req_atomic & mem_req;
                enable  = (~mem_req | dhit) & pipe_ready;
                if (mem_req & dhit & req_ren) begin
                    load_data = dmemload;
`ifdef DMEM_LLSC_EN
                end else if (mem_req & dhit & sc_req) begin
                    load_data = {{(DATA_W-1){1'b0}}, 1'b1};
                end else if (sc_fail) begin
                    load_data = '0;
`else
                end else if (mem_req & dhit & sc_req) begin
                    load_data = dmemload;
`endif
                end
                if (mem_req & dhit & ~pipe_ready) begin
                    state_nxt = HELD;
                end
            end
            HELD: begin
                // Access already completed; only wait for the rest of the pipe.
                if (pipe_ready) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            load_reg <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && (state_nxt == HELD)) begin
                load_reg <= load_data;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_count <= '0;
        end else if (stall_clr) begin
            stall_count <= '0;
        end else if (stall_inc && (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed self-checking bench for dmem_req_ctrl; LL/SC checks are built when DMEM_LLSC_EN is defined.
module tb_dmem_req_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_ren, req_wen, req_atomic;
    logic [31:0] req_addr, req_wdata;
    logic        halt, pipe_ready, dhit;
    logic [31:0] dmemload;
    logic        snoop_valid;
    logic [31:0] snoop_addr;
    logic        stall_clr;
    logic        dmemREN, dmemWEN, datomic;
    logic [31:0] dmemaddr, dmemstore;
    logic        enable;
    logic [31:0] load_data;
    logic [15:0] stall_count;

    int checks   = 0;
    int failures = 0;
    int wen_cnt  = 0;
    int wen_base;

    dmem_req_ctrl dut (
        .CLK(CLK), .RST(RST),
        .req_ren(req_ren), .req_wen(req_wen), .req_atomic(req_atomic),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .halt(halt), .pipe_ready(pipe_ready), .dhit(dhit), .dmemload(dmemload),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .stall_clr(stall_clr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .enable(enable),
        .load_data(load_data), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (dmemWEN) wen_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_req();
        req_ren     = 1'b0;
        req_wen     = 1'b0;
        req_atomic  = 1'b0;
        dhit        = 1'b0;
        halt        = 1'b0;
        snoop_valid = 1'b0;
        stall_clr   = 1'b0;
    endtask

    initial begin
        RST        = 1'b1;
        clear_req();
        req_addr   = '0;
        req_wdata  = '0;
        dmemload   = '0;
        snoop_addr = '0;
        pipe_ready = 1'b1;
        #3;
        check("rst_ren",    64'(dmemREN),     64'd0);
        check("rst_wen",    64'(dmemWEN),     64'd0);
        check("rst_enable", 64'(enable),      64'd1);
        check("rst_load",   64'(load_data),   64'd0);
        check("rst_stall",  64'(stall_count), 64'd0);
        step();
        RST = 1'b0;

        // Load with hit three cycles later
        req_ren = 1'b1; req_addr = 32'h100; dhit = 1'b0; pipe_ready = 1'b1;
        #1;
        check("ld_ren",     64'(dmemREN),  64'd1);
        check("ld_en_wait", 64'(enable),   64'd0);
        check("ld_addr",    64'(dmemaddr), 64'h100);
        step(); step(); step();
        check("ld_en_wait3", 64'(enable), 64'd0);
        dhit = 1'b1; dmemload = 32'hDEADBEEF;
        #1;
        check("ld_en_hit", 64'(enable),      64'd1);
        check("ld_data",   64'(load_data),   64'hDEADBEEF);
        check("ld_stall3", 64'(stall_count), 64'd3);
        step();
        clear_req();

        // Store hit while the rest of the pipe is stalled
        wen_base = wen_cnt;
        req_wen = 1'b1; req_addr = 32'h300; req_wdata = 32'h55; dhit = 1'b1; pipe_ready = 1'b0;
        #1;
        check("st_wen_hit", 64'(dmemWEN),   64'd1);
        check("st_en_hit",  64'(enable),    64'd0);
        check("st_store",   64'(dmemstore), 64'h55);
        step();
        dhit = 1'b0;
        #1;
        check("st_wen_held", 64'(dmemWEN), 64'd0);
        check("st_en_held",  64'(enable),  64'd0);
        step();
        pipe_ready = 1'b1;
        #1;
        check("st_en_adv",  64'(enable),  64'd1);
        check("st_wen_adv", 64'(dmemWEN), 64'd0);
        step();
        req_wen = 1'b0;
        #1;
        check("st_one_req", 64'(wen_cnt - wen_base), 64'd1);

        // Load hit held across a downstream stall
        req_ren = 1'b1; req_addr = 32'h104; dhit = 1'b1; dmemload = 32'hCAFE0001; pipe_ready = 1'b0;
        #1;
        check("lh_data_hit", 64'(load_data), 64'hCAFE0001);
        check("lh_en_hit",   64'(enable),    64'd0);
        step();
        dhit = 1'b0; dmemload = 32'h12345678;
        #1;
        check("lh_data_held", 64'(load_data), 64'hCAFE0001);
        check("lh_ren_held",  64'(dmemREN),   64'd0);
        step();
        pipe_ready = 1'b1;
        #1;
        check("lh_en_adv", 64'(enable), 64'd1);
        step();
        req_ren = 1'b0;
        #1;
        check("lh_data_idle", 64'(load_data), 64'hCAFE0001);
        check("lh_stall",     64'(stall_count), 64'd3);

        // Halt suppresses requests
        req_ren = 1'b1; halt = 1'b1; pipe_ready = 1'b0;
        #1;
        check("halt_ren",   64'(dmemREN), 64'd0);
        check("halt_en_lo", 64'(enable),  64'd0);
        pipe_ready = 1'b1;
        #1;
        check("halt_en_hi", 64'(enable), 64'd1);
        step();
        check("halt_stall", 64'(stall_count), 64'd3);
        clear_req();

`ifdef DMEM_LLSC_EN
        // LL then SC succeeds, second SC fails locally
        req_ren = 1'b1; req_atomic = 1'b1; req_addr = 32'h200; dhit = 1'b1; dmemload = 32'h9;
        #1;
        check("ll_datomic", 64'(datomic), 64'd1);
        step();
        clear_req();
        req_wen = 1'b1; req_atomic = 1'b1; req_addr = 32'h200; dhit = 1'b1;
        #1;
        check("sc1_wen",  64'(dmemWEN),   64'd1);
        check("sc1_data", 64'(load_data), 64'd1);
        check("sc1_en",   64'(enable),    64'd1);
        step();
        dhit = 1'b0;
        #1;
        check("sc2_wen",  64'(dmemWEN),   64'd0);
        check("sc2_data", 64'(load_data), 64'd0);
        check("sc2_en",   64'(enable),    64'd1);
        step();
        clear_req();

        // Snoop to same word kills the reservation
        req_ren = 1'b1; req_atomic = 1'b1; req_addr = 32'h200; dhit = 1'b1;
        step();
        clear_req();
        snoop_valid = 1'b1; snoop_addr = 32'h203;
        step();
        clear_req();
        req_wen = 1'b1; req_atomic = 1'b1; req_addr = 32'h200;
        #1;
        check("snp_sc_wen",  64'(dmemWEN),   64'd0);
        check("snp_sc_data", 64'(load_data), 64'd0);
        step();
        clear_req();

        // LL hit and matching snoop in the same cycle
        req_ren = 1'b1; req_atomic = 1'b1; req_addr = 32'h200; dhit = 1'b1;
        snoop_valid = 1'b1; snoop_addr = 32'h200;
        step();
        clear_req();
        req_wen = 1'b1; req_atomic = 1'b1; req_addr = 32'h200;
        #1;
        check("race_sc_wen",  64'(dmemWEN),   64'd0);
        check("race_sc_data", 64'(load_data), 64'd0);
        step();
        clear_req();
`else
        // SC goes to the dcache, which owns the outcome
        req_wen = 1'b1; req_atomic = 1'b1; req_addr = 32'h200; dhit = 1'b0;
        snoop_valid = 1'b1; snoop_addr = 32'h200;
        #1;
        check("sc_wen",     64'(dmemWEN), 64'd1);
        check("sc_datomic", 64'(datomic), 64'd1);
        check("sc_en_wait", 64'(enable),  64'd0);
        step();
        dhit = 1'b1; dmemload = 32'hA5;
        #1;
        check("sc_data", 64'(load_data), 64'hA5);
        check("sc_en",   64'(enable),    64'd1);
        step();
        clear_req();
`endif

        // Clear beats increment, then saturation
        req_ren = 1'b1; req_addr = 32'h400; dhit = 1'b0; stall_clr = 1'b1;
        step();
        check("clr_prio", 64'(stall_count), 64'd0);
        stall_clr = 1'b0;
        repeat (65541) @(posedge CLK);
        #1;
        check("stall_sat", 64'(stall_count), 64'hFFFF);

        // Reset while held: back to IDLE with cleared state
        dhit = 1'b1; dmemload = 32'h77; pipe_ready = 1'b0;
        step();
        dhit = 1'b0;
        #1;
        check("pre_rst_ren", 64'(dmemREN), 64'd0);
        RST = 1'b1;
        #1;
        check("mid_rst_stall", 64'(stall_count), 64'd0);
        check("mid_rst_load",  64'(load_data),   64'd0);
        check("mid_rst_ren",   64'(dmemREN),     64'd1);
        check("mid_rst_en",    64'(enable),      64'd0);
        step();
        RST = 1'b0;
        clear_req();
        pipe_ready = 1'b1;
        #1;
        check("post_rst_en",   64'(enable),    64'd1);
        check("post_rst_load", 64'(load_data), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
